// File: rtl/cluster_mem_arb.sv
// cluster_mem_arb: merges NUM_REQS cluster memory request streams into one
// downstream stream with round-robin arbitration. The source index is appended
// in the tag LSBs, and read responses are routed back to their cluster by that
// index. Outstanding reads are bounded per cluster, and both the request and
// response paths are registered.
module cluster_mem_arb #(
  parameter int unsigned NUM_REQS      = 4,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned TAG_IN_WIDTH  = 8,
  parameter int unsigned MAX_PENDING   = 16,
  localparam int unsigned SEL_BITS      = $clog2(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS,
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid_in,
  input  logic [NUM_REQS-1:0]                req_rw_in,
  input  logic [NUM_REQS*BE_WIDTH-1:0]       req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   req_tag_in,
  output logic [NUM_REQS-1:0]                req_ready_in,
  output logic                               req_valid_out,
  output logic                               req_rw_out,
  output logic [BE_WIDTH-1:0]                req_byteen_out,
  output logic [ADDR_WIDTH-1:0]              req_addr_out,
  output logic [DATA_WIDTH-1:0]              req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]           req_tag_out,
  input  logic                               req_ready_out,
  input  logic                               rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]              rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]           rsp_tag_in,
  output logic                               rsp_ready_in,
  output logic [NUM_REQS-1:0]                rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]     rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]   rsp_tag_out,
  input  logic [NUM_REQS-1:0]                rsp_ready_out,
  output logic                               busy
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  // Unpacked per-input views of the flattened request buses
  logic [BE_WIDTH-1:0]     be_arr   [NUM_REQS];
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQS];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQS];
  logic [TAG_IN_WIDTH-1:0] tag_arr  [NUM_REQS];

  // Arbitration state
  logic [SEL_BITS-1:0]     rr_ptr;
  logic [NUM_REQS-1:0]     eligible;
  logic                    grant_valid;
  logic [SEL_BITS-1:0]     grant_idx;
  logic [SEL_BITS-1:0]     scan_idx;
  logic                    load_en;
  logic                    req_fire;

  // Request output register
  logic                    req_valid_q;
  logic                    req_rw_q;
  logic [BE_WIDTH-1:0]     req_be_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_data_q;
  logic [TAG_OUT_WIDTH-1:0] req_tag_q;

  // Response register
  logic                    rsp_valid_q;
  logic [SEL_BITS-1:0]     rsp_sel_q;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_fire_in;

  // Outstanding read tracking
  logic [PEND_W-1:0]       pend [NUM_REQS];
  logic [NUM_REQS-1:0]     pend_inc;
  logic [NUM_REQS-1:0]     pend_dec;
  logic                    any_pend;

  // Slice flattened input buses; responses broadcast data/tag to every port
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_ports
    assign be_arr[g]   = req_byteen_in[g*BE_WIDTH +: BE_WIDTH];
    assign addr_arr[g] = req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[g]  = req_tag_in[g*TAG_IN_WIDTH +: TAG_IN_WIDTH];
    assign rsp_data_out[g*DATA_WIDTH +: DATA_WIDTH]     = rsp_data_q;
    assign rsp_tag_out[g*TAG_IN_WIDTH +: TAG_IN_WIDTH]  = rsp_tag_q;
  end

  // Eligibility: reads stall once a cluster hits its outstanding-read limit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pend[i] != PEND_MAX));
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan_idx = rr_ptr + SEL_BITS'(k);
      if (!grant_valid && eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Request handshake: the output register loads when empty or draining
  always_comb begin
    load_en      = !req_valid_q || req_ready_out;
    req_fire     = load_en && grant_valid;
    req_ready_in = req_fire ? (NUM_REQS'(1) << grant_idx) : '0;
  end

  // Request valid and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      if (load_en) begin
        req_valid_q <= grant_valid;
      end
      if (req_fire) begin
        rr_ptr <= grant_idx + SEL_BITS'(1);
      end
    end
  end

  // Request payload capture; contents are don't-care while invalid
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_rw_q   <= req_rw_in[grant_idx];
      req_be_q   <= be_arr[grant_idx];
      req_addr_q <= addr_arr[grant_idx];
      req_data_q <= data_arr[grant_idx];
      req_tag_q  <= {tag_arr[grant_idx], grant_idx};
    end
  end

  assign req_valid_out  = req_valid_q;
  assign req_rw_out     = req_rw_q;
  assign req_byteen_out = req_be_q;
  assign req_addr_out   = req_addr_q;
  assign req_data_out   = req_data_q;
  assign req_tag_out    = req_tag_q;

  // Response handshake: single in-order register, a stalled target blocks all
  always_comb begin
    rsp_ready_in  = !rsp_valid_q || rsp_ready_out[rsp_sel_q];
    rsp_fire_in   = rsp_valid_in && rsp_ready_in;
    rsp_valid_out = rsp_valid_q ? (NUM_REQS'(1) << rsp_sel_q) : '0;
  end

  // Response valid register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
    end else if (rsp_ready_in) begin
      rsp_valid_q <= rsp_valid_in;
    end
  end

  // Response payload capture; source index comes from the tag LSBs
  always_ff @(posedge clk) begin
    if (rsp_fire_in) begin
      rsp_data_q <= rsp_data_in;
      rsp_sel_q  <= rsp_tag_in[SEL_BITS-1:0];
      rsp_tag_q  <= rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];
    end
  end

  // Pending counter increments on accepted reads, decrements on delivered responses
  always_comb begin
    pend_inc = '0;
    pend_dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_inc[i] = req_fire && (grant_idx == SEL_BITS'(i)) && !req_rw_in[i];
      pend_dec[i] = rsp_valid_out[i] && rsp_ready_out[i];
    end
  end

  // Per-input outstanding read counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        assert (!(pend_dec[i] && (pend[i] == '0)));
        if (pend_inc[i] && !pend_dec[i]) begin
          pend[i] <= pend[i] + PEND_W'(1);
        end else if (!pend_inc[i] && pend_dec[i]) begin
          pend[i] <= pend[i] - PEND_W'(1);
        end
      end
    end
  end

  // Busy whenever any read is outstanding or an output register holds data
  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      any_pend = any_pend || (pend[i] != '0);
    end
    busy = any_pend || req_valid_q || rsp_valid_q;
  end

endmodule

// File: tb/tb_cluster_mem_arb.sv
// Directed scoreboard bench for cluster_mem_arb (4 ports, 64-bit data, MAX_PENDING=2).
module tb_cluster_mem_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned AW  = 26;
  localparam int unsigned TW  = 8;
  localparam int unsigned TOW = TW + 2;

  typedef struct {
    logic          rw;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TOW-1:0] tag;
  } req_exp_t;

  typedef struct {
    int            sel;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]  valid, rw;
  logic [BW-1:0] be   [N];
  logic [AW-1:0] addr [N];
  logic [DW-1:0] data [N];
  logic [TW-1:0] tag  [N];

  logic [N*BW-1:0] req_byteen_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N*DW-1:0] req_data_in;
  logic [N*TW-1:0] req_tag_in;
  logic [N-1:0]    req_ready_in;
  logic            req_valid_out, req_rw_out;
  logic [BW-1:0]   req_byteen_out;
  logic [AW-1:0]   req_addr_out;
  logic [DW-1:0]   req_data_out;
  logic [TOW-1:0]  req_tag_out;
  logic            req_ready_out;
  logic            rsp_valid_in;
  logic [DW-1:0]   rsp_data_in;
  logic [TOW-1:0]  rsp_tag_in;
  logic            rsp_ready_in;
  logic [N-1:0]    rsp_valid_out;
  logic [N*DW-1:0] rsp_data_out;
  logic [N*TW-1:0] rsp_tag_out;
  logic [N-1:0]    rsp_ready_out;
  logic            busy;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_byteen_in[g*BW +: BW] = be[g];
    assign req_addr_in[g*AW +: AW]   = addr[g];
    assign req_data_in[g*DW +: DW]   = data[g];
    assign req_tag_in[g*TW +: TW]    = tag[g];
  end

  cluster_mem_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW), .MAX_PENDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(valid), .req_rw_in(rw), .req_byteen_in(req_byteen_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
    .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  // Record the expected merged request for a grant to input g
  task automatic push_req(input int g);
    req_exp_t e;
    e.rw   = rw[g];
    e.be   = be[g];
    e.addr = addr[g];
    e.data = data[g];
    e.tag  = {tag[g], 2'(g)};
    req_q.push_back(e);
    mptr = (g + 1) % N;
  endtask

  task automatic check_req_out(input string name, input bit do_pop);
    req_exp_t e;
    chk({name, "_qnonempty"}, 64'(req_q.size() != 0), 64'd1);
    if (req_q.size() != 0) begin
      e = req_q[0];
      if (do_pop) void'(req_q.pop_front());
      chk({name, "_valid"}, 64'(req_valid_out), 64'd1);
      chk({name, "_rw"},    64'(req_rw_out), 64'(e.rw));
      chk({name, "_be"},    64'(req_byteen_out), 64'(e.be));
      chk({name, "_addr"},  64'(req_addr_out), 64'(e.addr));
      chk({name, "_data"},  req_data_out, e.data);
      chk({name, "_tag"},   64'(req_tag_out), 64'(e.tag));
    end
  endtask

  task automatic check_rsp_out(input string name, input bit do_pop);
    rsp_exp_t e;
    chk({name, "_qnonempty"}, 64'(rsp_q.size() != 0), 64'd1);
    if (rsp_q.size() != 0) begin
      e = rsp_q[0];
      if (do_pop) void'(rsp_q.pop_front());
      chk({name, "_valid"}, 64'(rsp_valid_out), 64'(4'b0001 << e.sel));
      chk({name, "_tag"},   64'(rsp_tag_out[e.sel*TW +: TW]), 64'(e.tag));
      chk({name, "_data"},  rsp_data_out[e.sel*DW +: DW], e.data);
    end
  endtask

  task automatic send_rsp(input int sel, input logic [TW-1:0] t, input logic [DW-1:0] d);
    rsp_exp_t e;
    rsp_valid_in = 1'b1;
    rsp_tag_in   = {t, 2'(sel)};
    rsp_data_in  = d;
    e.sel = sel;
    e.tag = t;
    e.data = d;
    rsp_q.push_back(e);
  endtask

  int rr_exp [6] = '{3, 0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    valid = '0;
    rw = '0;
    for (int i = 0; i < N; i++) begin
      be[i]   = 8'(i * 17 + 1);
      addr[i] = '0;
      data[i] = {$urandom, $urandom};
      tag[i]  = '0;
    end
    req_ready_out = 1'b1;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_tag_in    = '0;
    rsp_ready_out = '1;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", 64'(req_valid_out), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready_in", 64'(req_ready_in), 64'd0);
    cyc();
    reset = 1'b0;

    // Single read from input 2
    valid[2] = 1'b1; rw[2] = 1'b0; addr[2] = 26'h100; tag[2] = 8'h5A;
    @(negedge clk);
    chk("single_ready_in", 64'(req_ready_in), 64'b0100);
    push_req(2);
    cyc();
    valid[2] = 1'b0;
    @(negedge clk);
    check_req_out("single", 1'b1);
    chk("single_tag_const", 64'(req_tag_out), 64'h16A);
    chk("single_busy", 64'(busy), 64'd1);
    cyc();
    @(negedge clk);
    chk("single_drained", 64'(req_valid_out), 64'd0);
    chk("single_busy_pend", 64'(busy), 64'd1);
    cyc();

    // Response routed to input 2, held while input 2 is not ready
    rsp_ready_out = 4'b1011;
    send_rsp(2, 8'h5A, 64'hDEAD);
    @(negedge clk);
    chk("rsp_ready_empty", 64'(rsp_ready_in), 64'd1);
    cyc();
    rsp_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_rsp_out("rsp_hold", 1'b0);
      chk("rsp_ready_blocked", 64'(rsp_ready_in), 64'd0);
      cyc();
    end
    rsp_ready_out = 4'b1111;
    @(negedge clk);
    chk("rsp_ready_release", 64'(rsp_ready_in), 64'd1);
    check_rsp_out("rsp_release", 1'b1);
    cyc();
    @(negedge clk);
    chk("rsp_drained", 64'(rsp_valid_out), 64'd0);
    chk("rsp_idle_busy", 64'(busy), 64'd0);
    cyc();

    // Round robin: all inputs issue writes continuously
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b1; rw[i] = 1'b1; addr[i] = 26'(32'h200 + i); tag[i] = 8'(8'h10 + i);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready_in), 64'(4'b0001 << rr_exp[c]));
      if (c > 0) check_req_out("rr_out", 1'b1);
      push_req(rr_exp[c]);
      cyc();
    end
    valid = '0;
    @(negedge clk);
    check_req_out("rr_last", 1'b1);
    chk("rr_idle_ready", 64'(req_ready_in), 64'd0);
    cyc();

    // Backpressure: output must hold while downstream stalls
    valid[0] = 1'b1; addr[0] = 26'h300;
    @(negedge clk);
    chk("bp_grant0", 64'(req_ready_in), 64'b0001);
    push_req(0);
    cyc();
    req_ready_out = 1'b0;
    addr[0] = 26'h301;
    valid[3] = 1'b1; addr[3] = 26'h333;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_in_zero", 64'(req_ready_in), 64'd0);
      check_req_out("bp_hold", 1'b0);
      cyc();
    end
    req_ready_out = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 64'(req_ready_in), 64'(4'b0001 << rr_pick(4'b1001, mptr)));
    chk("bp_release_grant3", 64'(req_ready_in), 64'b1000);
    check_req_out("bp_release_out", 1'b1);
    push_req(3);
    cyc();
    valid = '0;
    @(negedge clk);
    check_req_out("bp_next", 1'b1);
    cyc();

    // Throttle: input 1 reads stall at two outstanding, writes still pass
    valid[1] = 1'b1; rw[1] = 1'b0; addr[1] = 26'h400;
    for (int k = 0; k < 3; k++) begin
      tag[1] = 8'(8'h20 + k);
      @(negedge clk);
      if (k < 2) begin
        chk("thr_read_accept", 64'(req_ready_in), 64'b0010);
        push_req(1);
      end else begin
        chk("thr_read_held", 64'(req_ready_in), 64'd0);
      end
      if (k > 0) check_req_out("thr_out", 1'b1);
      cyc();
    end
    rw[1] = 1'b1; tag[1] = 8'h30;
    @(negedge clk);
    chk("thr_write_pass", 64'(req_ready_in), 64'b0010);
    push_req(1);
    cyc();
    rw[1] = 1'b0; tag[1] = 8'h22;
    @(negedge clk);
    check_req_out("thr_write_out", 1'b1);
    chk("thr_read_still_held", 64'(req_ready_in), 64'd0);
    cyc();
    send_rsp(1, 8'h20, 64'hBEEF);
    @(negedge clk);
    chk("thr_rsp_ready", 64'(rsp_ready_in), 64'd1);
    chk("thr_held_rsp_in", 64'(req_ready_in), 64'd0);
    cyc();
    rsp_valid_in = 1'b0;
    @(negedge clk);
    check_rsp_out("thr_rsp_out", 1'b1);
    chk("thr_held_rsp_out", 64'(req_ready_in), 64'd0);
    cyc();
    @(negedge clk);
    chk("thr_third_accept", 64'(req_ready_in), 64'b0010);
    push_req(1);
    cyc();
    valid = '0;
    @(negedge clk);
    check_req_out("thr_third_out", 1'b1);
    cyc();

    // Reset mid-operation with both registers valid and pend[0] at its limit
    valid[0] = 1'b1; rw[0] = 1'b0; addr[0] = 26'h500; tag[0] = 8'h50;
    @(negedge clk);
    chk("mr_read0_a", 64'(req_ready_in), 64'b0001);
    push_req(0);
    cyc();
    @(negedge clk);
    check_req_out("mr_out_a", 1'b1);
    chk("mr_read0_b", 64'(req_ready_in), 64'b0001);
    push_req(0);
    cyc();
    req_ready_out = 1'b0;
    rsp_ready_out = 4'b1101;
    send_rsp(1, 8'h40, 64'h1234_5678);
    @(negedge clk);
    chk("mr_rsp_ready", 64'(rsp_ready_in), 64'd1);
    cyc();
    rsp_valid_in = 1'b0;
    @(negedge clk);
    chk("mr_pre_req_valid", 64'(req_valid_out), 64'd1);
    chk("mr_pre_rsp_valid", 64'(rsp_valid_out), 64'b0010);
    chk("mr_pre_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_req_valid", 64'(req_valid_out), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid_out), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    req_q.delete();
    rsp_q.delete();
    mptr = 0;
    cyc();
    reset = 1'b0;
    req_ready_out = 1'b1;
    rsp_ready_out = 4'b1111;
    for (int i = 0; i < N; i++) begin
      valid[i] = 1'b1; rw[i] = 1'b0; addr[i] = 26'(32'h600 + i); tag[i] = 8'(8'h60 + i);
    end
    @(negedge clk);
    chk("mr_ptr_zero", 64'(req_ready_in), 64'b0001);
    push_req(0);
    cyc();
    valid = '0;
    @(negedge clk);
    check_req_out("mr_after", 1'b1);
    chk("mr_no_rsp", 64'(rsp_valid_out), 64'd0);
    cyc();

    chk("end_req_q_empty", 64'(req_q.size()), 64'd0);
    chk("end_rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
